// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: ASCII codes, FSM encoding, error codes.
// Lowercase command folding is used only when UART_CMD_LOWER_EN is defined.
package uart_cmd_pkg;

   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_M  = 8'h4D;
   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_WAIT_CR = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COLLECT = ST_COLLECT,
      WAIT_CR = ST_WAIT_CR
   } state_e;

   localparam logic [1:0] ERR_CHAR    = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam int unsigned NUM_DIGITS = 6;

   // Maps the lowercase command letters onto their uppercase forms; everything else passes through.
   function automatic logic [7:0] fold_cmd_case(input logic [7:0] b);
      case (b)
         8'h72:   return CH_R;
         8'h63:   return CH_C;
         8'h6D:   return CH_M;
         8'h73:   return CH_S;
         default: return b;
      endcase
   endfunction

   function automatic logic [6:0] two_digit(input logic [3:0] hi, input logic [3:0] lo);
      return (7'({3'b000, hi}) * 7'd10) + 7'({3'b000, lo});
   endfunction

endpackage

// File: rtl/uart_cmd_parser_timer.sv
// Inter-byte timeout counter: clears on clr_i, counts while en_i, pulses expire_o on its last count.
module cmd_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A clear in the same cycle means a byte arrived, and the byte takes precedence.
   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command decoder behind uart_rx: R/C/M pulses and "S"+HHMMSS+CR time setting.
// Define UART_CMD_LOWER_EN to also accept lowercase r/c/m/s.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       cmd_run_stop,
   output logic       cmd_clear,
   output logic       cmd_mode,
   output logic       set_valid,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       err,
   output logic [1:0] err_code
);

   // rx_done is a one-cycle strobe with no backpressure: rx_data is consumed exactly in that cycle.
   logic [7:0] byte_c;
`ifdef UART_CMD_LOWER_EN
   assign byte_c = fold_cmd_case(rx_data);
`else
   assign byte_c = rx_data;
`endif

   state_e                        state_q, state_d;
   logic [2:0]                    idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]    digit_q, digit_d;
   logic                          run_q, run_d;
   logic                          clear_q, clear_d;
   logic                          mode_q, mode_d;
   logic                          setv_q, setv_d;
   logic                          err_q, err_d;
   logic [1:0]                    code_q, code_d;
   logic [4:0]                    hour_q, hour_d;
   logic [5:0]                    min_q, min_d;
   logic [5:0]                    sec_q, sec_d;

   logic       expire;
   logic       is_digit;
   logic [6:0] hour_v, min_v, sec_v;
   logic       in_range;

   cmd_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (rx_done || (state_q == IDLE)),
      .en_i    (state_q != IDLE),
      .expire_o(expire)
   );

   // '0'..'9' carry their value in the low nibble, so no subtraction is needed.
   assign is_digit = (byte_c >= CH_0) && (byte_c <= CH_9);
   assign hour_v   = two_digit(digit_q[0], digit_q[1]);
   assign min_v    = two_digit(digit_q[2], digit_q[3]);
   assign sec_v    = two_digit(digit_q[4], digit_q[5]);
   assign in_range = (hour_v <= 7'd23) && (min_v <= 7'd59) && (sec_v <= 7'd59);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      digit_d = digit_q;
      run_d   = 1'b0;
      clear_d = 1'b0;
      mode_d  = 1'b0;
      setv_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;

      if (rx_done) begin
         case (state_q)
            IDLE: begin
               if (byte_c == CH_R) begin
                  run_d = 1'b1;
               end else if (byte_c == CH_C) begin
                  clear_d = 1'b1;
               end else if (byte_c == CH_M) begin
                  mode_d = 1'b1;
               end else if (byte_c == CH_S) begin
                  idx_d   = 3'd0;
                  state_d = COLLECT;
               end else if ((byte_c != CH_CR) && (byte_c != CH_LF)) begin
                  err_d  = 1'b1;
                  code_d = ERR_CHAR;
               end
            end
            COLLECT: begin
               if (is_digit) begin
                  digit_d[idx_q] = byte_c[3:0];
                  idx_d          = idx_q + 3'd1;
                  if (idx_q == 3'd5) begin
                     state_d = WAIT_CR;
                  end
               end else if (byte_c == CH_S) begin
                  idx_d = 3'd0;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CHAR;
                  state_d = IDLE;
               end
            end
            WAIT_CR: begin
               if (byte_c == CH_CR) begin
                  state_d = IDLE;
                  if (in_range) begin
                     setv_d = 1'b1;
                     hour_d = hour_v[4:0];
                     min_d  = min_v[5:0];
                     sec_d  = sec_v[5:0];
                  end else begin
                     err_d  = 1'b1;
                     code_d = ERR_RANGE;
                  end
               end else if (byte_c == CH_S) begin
                  idx_d   = 3'd0;
                  state_d = COLLECT;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CHAR;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (expire) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         digit_q <= '0;
         run_q   <= 1'b0;
         clear_q <= 1'b0;
         mode_q  <= 1'b0;
         setv_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         run_q   <= run_d;
         clear_q <= clear_d;
         mode_q  <= mode_d;
         setv_q  <= setv_d;
         err_q   <= err_d;
         code_q  <= code_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
      end
   end

   assign cmd_run_stop = run_q;
   assign cmd_clear    = clear_q;
   assign cmd_mode     = mode_q;
   assign set_valid    = setv_q;
   assign set_hour     = hour_q;
   assign set_min      = min_q;
   assign set_sec      = sec_q;
   assign err          = err_q;
   assign err_code     = code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus random byte streams
// checked against a string/queue level reference model.
module tb_uart_cmd_parser;

   localparam int TB_TIMEOUT = 50;
   localparam logic [7:0] K_R = 8'h52, K_C = 8'h43, K_M = 8'h4D, K_S = 8'h53;
   localparam logic [7:0] K_CR = 8'h0D, K_LF = 8'h0A;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       cmd_run_stop, cmd_clear, cmd_mode, set_valid, err;
   logic [4:0] set_hour;
   logic [5:0] set_min, set_sec;
   logic [1:0] err_code;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_parser #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .cmd_run_stop(cmd_run_stop),
      .cmd_clear   (cmd_clear),
      .cmd_mode    (cmd_mode),
      .set_valid   (set_valid),
      .set_hour    (set_hour),
      .set_min     (set_min),
      .set_sec     (set_sec),
      .err         (err),
      .err_code    (err_code)
   );

   // ---------------- reference model ----------------
   // Expected word: {run, clear, mode, set_valid, err, err_code, hour, min, sec}
   logic [23:0] exp_q[$];
   bit          m_in_seq;
   int          m_digits[$];
   int          m_gap;
   logic [1:0]  m_code;
   logic [4:0]  m_h;
   logic [5:0]  m_m, m_s;

   function automatic logic [7:0] m_fold(input logic [7:0] b);
`ifdef UART_CMD_LOWER_EN
      if (b == "r") return K_R;
      if (b == "c") return K_C;
      if (b == "m") return K_M;
      if (b == "s") return K_S;
`endif
      return b;
   endfunction

   task automatic model_reset();
      m_in_seq = 1'b0;
      m_digits.delete();
      m_gap  = 0;
      m_code = 2'd0;
      m_h    = 5'd0;
      m_m    = 6'd0;
      m_s    = 6'd0;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] raw);
      logic [7:0] b;
      logic [4:0] p;
      int h, mi, se;
      b = m_fold(raw);
      p = 5'b00000;
      m_gap = 0;
      if (!m_in_seq) begin
         if (b == K_R) p = 5'b10000;
         else if (b == K_C) p = 5'b01000;
         else if (b == K_M) p = 5'b00100;
         else if (b == K_S) begin
            m_in_seq = 1'b1;
            m_digits.delete();
         end else if (b != K_CR && b != K_LF) begin
            p = 5'b00001; m_code = 2'd1;
         end
      end else begin
         if (b == K_S) begin
            m_digits.delete();
         end else if (b >= "0" && b <= "9" && m_digits.size() < 6) begin
            m_digits.push_back(int'(b) - 48);
         end else if (b == K_CR && m_digits.size() == 6) begin
            h  = m_digits[0] * 10 + m_digits[1];
            mi = m_digits[2] * 10 + m_digits[3];
            se = m_digits[4] * 10 + m_digits[5];
            if (h <= 23 && mi <= 59 && se <= 59) begin
               p = 5'b00010;
               m_h = 5'(h); m_m = 6'(mi); m_s = 6'(se);
            end else begin
               p = 5'b00001; m_code = 2'd2;
            end
            m_in_seq = 1'b0;
         end else begin
            p = 5'b00001; m_code = 2'd1;
            m_in_seq = 1'b0;
         end
      end
      exp_q.push_back({p, m_code, m_h, m_m, m_s});
   endtask

   // A set sequence that stays silent for TB_TIMEOUT cycles is aborted.
   task automatic model_idle();
      logic [4:0] p;
      p = 5'b00000;
      m_gap++;
      if (m_in_seq && m_gap == TB_TIMEOUT) begin
         p = 5'b00001; m_code = 2'd3;
         m_in_seq = 1'b0;
      end
      exp_q.push_back({p, m_code, m_h, m_m, m_s});
   endtask

   function automatic logic [23:0] obs_word();
      return {cmd_run_stop, cmd_clear, cmd_mode, set_valid, err, err_code, set_hour, set_min, set_sec};
   endfunction

   // ---------------- drivers (entered and left on a negedge) ----------------
   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom_range(0, 255));
      model_byte(b);
   endtask

   task automatic idle_step();
      @(negedge clk);
      model_idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (obs_word() !== 24'h0) begin
            failures++;
            $display("FAIL reset: outputs %h expected %h", obs_word(), 24'h0);
         end
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_commands();
      logic [7:0]  tab[3];
      logic [23:0] exp_w;
      tab = '{K_R, K_C, K_M};
      for (int i = 0; i < 3; i++) begin
         send(tab[i]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL commands pulse %0d: got %h expected %h", i, obs_word(), exp_w);
         end
         idle_step();
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL commands width %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
   endtask

   task automatic test_set_time();
      string       s;
      logic [7:0]  b;
      logic [23:0] exp_w;
      s = "S235959";
      for (int i = 0; i <= s.len(); i++) begin
         b = (i == s.len()) ? K_CR : s[i];
         send(b);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL set_time byte %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
      checks++;
      if ({set_valid, set_hour, set_min, set_sec} !== {1'b1, 5'd23, 6'd59, 6'd59}) begin
         failures++;
         $display("FAIL set_time values: got v=%0b %0d:%0d:%0d expected v=1 23:59:59",
                  set_valid, set_hour, set_min, set_sec);
      end
   endtask

   task automatic test_range();
      string       s;
      logic [7:0]  b;
      logic [23:0] exp_w;
      s = "S246000";
      for (int i = 0; i <= s.len(); i++) begin
         b = (i == s.len()) ? K_CR : s[i];
         send(b);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL range_bad byte %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
      checks++;
      if ({err, err_code, set_valid, set_hour} !== {1'b1, 2'd2, 1'b0, 5'd23}) begin
         failures++;
         $display("FAIL range_err: got err=%0b code=%0d v=%0b hour=%0d expected err=1 code=2 v=0 hour=23",
                  err, err_code, set_valid, set_hour);
      end
      s = "S120000";
      for (int i = 0; i <= s.len(); i++) begin
         b = (i == s.len()) ? K_CR : s[i];
         send(b);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL range_good byte %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
      checks++;
      if ({set_valid, err, set_hour, set_min, set_sec} !== {1'b1, 1'b0, 5'd12, 6'd0, 6'd0}) begin
         failures++;
         $display("FAIL range_good values: got v=%0b err=%0b %0d:%0d:%0d expected v=1 err=0 12:0:0",
                  set_valid, err, set_hour, set_min, set_sec);
      end
   endtask

   task automatic test_bad_char();
      string       s;
      logic [23:0] exp_w;
      s = "S12AR";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL bad_char byte %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
      checks++;
      if ({cmd_run_stop, err, err_code} !== {1'b1, 1'b0, 2'd1}) begin
         failures++;
         $display("FAIL bad_char recover: got run=%0b err=%0b code=%0d expected run=1 err=0 code=1",
                  cmd_run_stop, err, err_code);
      end
   endtask

   task automatic test_timeout();
      string       s;
      logic [23:0] exp_w;
      // Silent for the full window: abort with code 3.
      s = "S12";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         void'(exp_q.pop_front());
      end
      for (int k = 1; k <= TB_TIMEOUT + 1; k++) begin
         idle_step();
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL timeout idle %0d: got %h expected %h", k, obs_word(), exp_w);
         end
         if (k == TB_TIMEOUT) begin
            checks++;
            if ({err, err_code} !== {1'b1, 2'd3}) begin
               failures++;
               $display("FAIL timeout code: got err=%0b code=%0d expected err=1 code=3", err, err_code);
            end
         end
      end
      // Byte lands on the expiry cycle: it is processed and the sequence completes.
      s = "S12";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         void'(exp_q.pop_front());
      end
      repeat (TB_TIMEOUT - 1) begin
         idle_step();
         void'(exp_q.pop_front());
      end
      s = "3456";
      for (int i = 0; i <= s.len(); i++) begin
         send((i == s.len()) ? K_CR : s[i]);
         exp_w = exp_q.pop_front();
         checks++;
         if (obs_word() !== exp_w) begin
            failures++;
            $display("FAIL timeout_edge byte %0d: got %h expected %h", i, obs_word(), exp_w);
         end
      end
      checks++;
      if ({set_valid, set_hour, set_min, set_sec} !== {1'b1, 5'd12, 6'd34, 6'd56}) begin
         failures++;
         $display("FAIL timeout_edge values: got v=%0b %0d:%0d:%0d expected v=1 12:34:56",
                  set_valid, set_hour, set_min, set_sec);
      end
   endtask

   task automatic test_reset_mid();
      string       s;
      logic [7:0]  b;
      logic [23:0] exp_w;
      s = "S1234";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         void'(exp_q.pop_front());
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (obs_word() !== 24'h0) begin
            failures++;
            $display("FAIL reset_mid zero: got %h expected %h", obs_word(), 24'h0);
         end
      end
      rst = 1'b0;
      model_reset();
`ifdef UART_CMD_LOWER_EN
      s = "S010203";
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) s = "s010203";
`else
      s = "S010203";
      for (int pass = 0; pass < 1; pass++) begin
`endif
         for (int i = 0; i <= s.len(); i++) begin
            b = (i == s.len()) ? K_CR : s[i];
            send(b);
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_word() !== exp_w) begin
               failures++;
               $display("FAIL reset_mid pass %0d byte %0d: got %h expected %h", pass, i, obs_word(), exp_w);
            end
         end
         checks++;
         if ({set_valid, set_hour, set_min, set_sec} !== {1'b1, 5'd1, 6'd2, 6'd3}) begin
            failures++;
            $display("FAIL reset_mid values: got v=%0b %0d:%0d:%0d expected v=1 1:2:3",
                     set_valid, set_hour, set_min, set_sec);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  bq[$];
      logic [7:0]  misc[8];
      logic [23:0] exp_w;
      int          gap;
      misc = '{K_R, K_C, K_M, K_LF, "r", "c", "m", "s"};
      for (int item = 0; item < 120; item++) begin
         bq.delete();
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               bq.push_back(($urandom_range(0, 1) == 0) ? K_S : 8'h73);
               bq.push_back(8'h30 + 8'($urandom_range(0, 2)));
               repeat (5) bq.push_back(8'h30 + 8'($urandom_range(0, 9)));
               if ($urandom_range(0, 5) != 0) bq.push_back(K_CR);
            end
            3, 4: bq.push_back(8'h30 + 8'($urandom_range(0, 9)));
            5:    bq.push_back(K_S);
            6:    bq.push_back(K_CR);
            7, 8: bq.push_back(misc[$urandom_range(0, 7)]);
            default: bq.push_back(8'($urandom_range(0, 255)));
         endcase
         foreach (bq[i]) begin
            send(bq[i]);
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_word() !== exp_w) begin
               failures++;
               $display("FAIL random item %0d byte %h: got %h expected %h", item, bq[i], obs_word(), exp_w);
            end
         end
         gap = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) gap = TB_TIMEOUT - 1 + 2 * $urandom_range(0, 1);
         repeat (gap) begin
            idle_step();
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_word() !== exp_w) begin
               failures++;
               $display("FAIL random idle after item %0d: got %h expected %h", item, obs_word(), exp_w);
            end
         end
      end
   endtask

   // ---------------- sequencing and report ----------------
   initial begin
      rst     = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      model_reset();
      @(negedge clk);
      test_reset();
      test_commands();
      test_set_time();
      test_range();
      test_bad_char();
      test_timeout();
      test_reset_mid();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
